// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register and writeback source selection.
//   clk, rst (async, active-low)
//   in_valid, stall, flush          - pipeline control from the hazard logic
//   mem_read_data, mem_ALU_result,
//   mem_pc_plus4, mem_Rd,
//   mem_reg_write, mem_mem_to_reg,
//   mem_link                        - MEM-stage payload captured each cycle
//   wb_Rd, wb_write_data,
//   wb_reg_write, wb_valid          - register-file write port / forwarding inputs
//   retire_count                    - count of instructions captured into WB
module mem_wb_stage #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic [DATA_W-1:0] mem_ALU_result,
  input  logic [DATA_W-1:0] mem_pc_plus4,
  input  logic [REG_W-1:0]  mem_Rd,
  input  logic              mem_reg_write,
  input  logic              mem_mem_to_reg,
  input  logic              mem_link,
  output logic [REG_W-1:0]  wb_Rd,
  output logic [DATA_W-1:0] wb_write_data,
  output logic              wb_reg_write,
  output logic              wb_valid,
  output logic [CNT_W-1:0]  retire_count
);

  // Payload held in MEM/WB; only valid/reg_write are touched by a flush.
  typedef struct packed {
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] pc_plus4;
    logic [REG_W-1:0]  rd;
    logic              mem_to_reg;
    logic              link;
  } wb_fields_t;

  wb_fields_t       fields_q;
  logic             valid_q;
  logic             reg_write_q;
  logic [CNT_W-1:0] count_q;

  // A retire is any real instruction actually moving into WB.
  logic retire;
  assign retire = in_valid & ~stall & ~flush;

  // Control bits: flush wins over stall, which wins over a normal capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (flush) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (!stall) begin
      valid_q     <= in_valid;
      reg_write_q <= mem_reg_write;
    end
  end

  // Data fields: held on flush too, since an invalid slot never writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fields_q <= '0;
    end else if (!flush && !stall) begin
      fields_q.read_data  <= mem_read_data;
      fields_q.alu_result <= mem_ALU_result;
      fields_q.pc_plus4   <= mem_pc_plus4;
      fields_q.rd         <= mem_Rd;
      fields_q.mem_to_reg <= mem_mem_to_reg;
      fields_q.link       <= mem_link;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (retire) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Writeback source select: link beats load beats ALU.
  always_comb begin
    wb_write_data = fields_q.alu_result;
    if (fields_q.link) begin
      wb_write_data = fields_q.pc_plus4;
    end else if (fields_q.mem_to_reg) begin
      wb_write_data = fields_q.read_data;
    end
  end

  assign wb_Rd        = fields_q.rd;
  assign wb_valid     = valid_q;
  assign wb_reg_write = valid_q & reg_write_q & (fields_q.rd != REG_W'(ZERO_REG));
  assign retire_count = count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
// A second instance with a 4-bit counter exercises counter wrap.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid, stall, flush;
  logic [63:0] mem_read_data, mem_ALU_result, mem_pc_plus4;
  logic [4:0]  mem_Rd;
  logic        mem_reg_write, mem_mem_to_reg, mem_link;

  logic [4:0]  wb_Rd;
  logic [63:0] wb_write_data;
  logic        wb_reg_write, wb_valid;
  logic [31:0] retire_count;

  logic [4:0]  s_wb_Rd;
  logic [63:0] s_wb_write_data;
  logic        s_wb_reg_write, s_wb_valid;
  logic [3:0]  s_retire_count;

  int n_checks = 0;
  int n_fail   = 0;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .mem_read_data(mem_read_data), .mem_ALU_result(mem_ALU_result),
    .mem_pc_plus4(mem_pc_plus4), .mem_Rd(mem_Rd), .mem_reg_write(mem_reg_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_link(mem_link),
    .wb_Rd(wb_Rd), .wb_write_data(wb_write_data), .wb_reg_write(wb_reg_write),
    .wb_valid(wb_valid), .retire_count(retire_count)
  );

  mem_wb_stage #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .mem_read_data(mem_read_data), .mem_ALU_result(mem_ALU_result),
    .mem_pc_plus4(mem_pc_plus4), .mem_Rd(mem_Rd), .mem_reg_write(mem_reg_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_link(mem_link),
    .wb_Rd(s_wb_Rd), .wb_write_data(s_wb_write_data), .wb_reg_write(s_wb_reg_write),
    .wb_valid(s_wb_valid), .retire_count(s_retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: what instruction sits in WB and what it will write.
  logic        m_valid;
  logic        m_writes;
  logic [4:0]  m_rd;
  logic [63:0] m_data;
  longint unsigned m_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid = 1'b0; m_writes = 1'b0; m_rd = '0; m_data = '0; m_cnt = 0;
    end else if (flush) begin
      m_valid = 1'b0; m_writes = 1'b0;
    end else if (!stall) begin
      m_valid  = in_valid;
      m_rd     = mem_Rd;
      m_writes = in_valid && mem_reg_write && (mem_Rd != 5'd31);
      m_data   = mem_link ? mem_pc_plus4 : (mem_mem_to_reg ? mem_read_data : mem_ALU_result);
      if (in_valid) m_cnt = (m_cnt + 1) % (64'd1 << 32);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("m_valid", 64'(wb_valid), 64'(m_valid));
      chk("m_reg_write", 64'(wb_reg_write), 64'(m_writes));
      chk("m_count", 64'(retire_count), m_cnt);
      chk("m_count_small", 64'(s_retire_count), m_cnt % 16);
      if (m_valid) begin
        chk("m_rd", 64'(wb_Rd), 64'(m_rd));
        chk("m_data", wb_write_data, m_data);
      end
    end
  end

  // Apply one set of MEM inputs, then advance past the next rising edge.
  task automatic cyc(input logic v, input logic s, input logic f,
                     input logic [63:0] rdat, input logic [63:0] alu, input logic [63:0] pc4,
                     input logic [4:0] rd, input logic rw, input logic m2r, input logic lnk);
    in_valid = v; stall = s; flush = f;
    mem_read_data = rdat; mem_ALU_result = alu; mem_pc_plus4 = pc4;
    mem_Rd = rd; mem_reg_write = rw; mem_mem_to_reg = m2r; mem_link = lnk;
    @(posedge clk); #1;
  endtask

  task automatic rand_inputs();
    in_valid = 1'($urandom); stall = 1'($urandom); flush = 1'($urandom);
    mem_read_data = {$urandom, $urandom}; mem_ALU_result = {$urandom, $urandom};
    mem_pc_plus4 = {$urandom, $urandom}; mem_Rd = 5'($urandom);
    mem_reg_write = 1'($urandom); mem_mem_to_reg = 1'($urandom); mem_link = 1'($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(wb_valid), 64'd0);
    chk({tag, "_reg_write"}, 64'(wb_reg_write), 64'd0);
    chk({tag, "_rd"}, 64'(wb_Rd), 64'd0);
    chk({tag, "_data"}, wb_write_data, 64'd0);
    chk({tag, "_count"}, 64'(retire_count), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    // Reset held with random inputs toggling.
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      @(posedge clk); #1;
    end
    chk_all_zero("reset_hold");
    rst = 1'b1;
    #1;
    chk_all_zero("reset_release");
    #1;

    // First capture after reset.
    cyc(1, 0, 0, 64'h0, 64'h1234, 64'h0, 5'd3, 1, 0, 0);
    chk("first_data", wb_write_data, 64'h1234);
    chk("first_rd", 64'(wb_Rd), 64'd3);
    chk("first_reg_write", 64'(wb_reg_write), 64'd1);
    chk("first_count", 64'(retire_count), 64'd1);

    // Load select, then link beating load.
    cyc(1, 0, 0, 64'hDEADBEEF00000001, 64'h40, 64'h0, 5'd7, 1, 1, 0);
    chk("load_data", wb_write_data, 64'hDEADBEEF00000001);
    cyc(1, 0, 0, 64'hDEADBEEF00000001, 64'h40, 64'h104, 5'd30, 1, 1, 1);
    chk("link_data", wb_write_data, 64'h104);
    chk("link_count", 64'(retire_count), 64'd3);

    // XZR destination: valid but no write, still retires.
    cyc(1, 0, 0, 64'h0, 64'h99, 64'h0, 5'd31, 1, 0, 0);
    chk("xzr_reg_write", 64'(wb_reg_write), 64'd0);
    chk("xzr_valid", 64'(wb_valid), 64'd1);
    chk("xzr_count", 64'(retire_count), 64'd4);

    // Capture Rd=5 / 0x55, then stall three cycles with changing inputs.
    cyc(1, 0, 0, 64'h0, 64'h55, 64'h0, 5'd5, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 64'hAAAA + 64'(i), 64'h66 + 64'(i), 64'h200, 5'(6 + i), 1, 0, 0);
      chk("stall_rd", 64'(wb_Rd), 64'd5);
      chk("stall_data", wb_write_data, 64'h55);
      chk("stall_reg_write", 64'(wb_reg_write), 64'd1);
      chk("stall_count", 64'(retire_count), 64'd5);
    end
    cyc(1, 1, 1, 64'h0, 64'h77, 64'h0, 5'd8, 1, 0, 0);
    chk("flush_valid", 64'(wb_valid), 64'd0);
    chk("flush_reg_write", 64'(wb_reg_write), 64'd0);
    chk("flush_count", 64'(retire_count), 64'd5);
    cyc(0, 0, 0, 64'h0, 64'h88, 64'h0, 5'd9, 1, 0, 0);
    chk("bubble_reg_write", 64'(wb_reg_write), 64'd0);
    chk("bubble_count", 64'(retire_count), 64'd5);

    // Wrap the 4-bit counter; interleaved bubbles must not count.
    for (int i = 0; i < 11; i++) begin
      cyc(1, 0, 0, 64'h0, 64'(i), 64'h0, 5'(i), 1, 0, 0);
      cyc(0, 0, 0, 64'h0, 64'hF0, 64'h0, 5'd1, 1, 0, 0);
    end
    chk("wrap_small", 64'(s_retire_count), 64'd0);
    chk("wrap_big", 64'(retire_count), 64'd16);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 64'h0, 64'(i), 64'h0, 5'd2, 0, 0, 0);
    chk("post_wrap_small", 64'(s_retire_count), 64'd5);

    // Async reset between edges while a write is pending.
    cyc(1, 0, 0, 64'h0, 64'hCAFE, 64'h0, 5'd9, 1, 0, 0);
    chk("pre_reset_reg_write", 64'(wb_reg_write), 64'd1);
    rst = 1'b0;
    #1;
    chk_all_zero("async_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    #1;

    // Random traffic, checked by the model every cycle.
    for (int i = 0; i < 60; i++) begin
      rand_inputs();
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 3) == 0) mem_Rd = 5'd31;
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
